// File: rtl/half_adder_pkg.sv
// Shared types and constants for the vectorised half adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package half_adder_pkg;

  // Lane count used when the instantiating block does not override WIDTH.
  localparam int HA_WIDTH_DEFAULT = 1;

  // Bits needed to hold a lane count in the range 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Result of one half-adder lane.
  typedef struct packed {
    logic sum;
    logic carry;
  } ha_result_t;

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// Single-bit combinational half adder: sum = a^b, carry = a&b.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the output follows the inputs.
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output ha_result_t res
);

  // Lane function.
  always_comb begin
    res       = '0;
    res.sum   = a ^ b;
    res.carry = a & b;
  end

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes plus carry OR-reduction and popcount.
// Latency: 1 cycle with OUT_REG=1; 0 cycles for data with OUT_REG=0 (out_valid always 1 cycle).
// Backpressure: none; the consumer must accept every out_valid pulse.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH   = HA_WIDTH_DEFAULT,
  parameter bit OUT_REG = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              s,
  output logic [WIDTH-1:0]              c,
  output logic                          carry_any,
  output logic [cnt_width(WIDTH)-1:0]   carry_cnt
);

  localparam int CW = cnt_width(WIDTH);

  ha_result_t        lane_res [WIDTH];
  logic [WIDTH-1:0]  s_comb;
  logic [WIDTH-1:0]  c_comb;
  logic              carry_any_comb;
  logic [CW-1:0]     carry_cnt_comb;

  // One cell per lane; lanes never interact.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .res (lane_res[i])
    );
  end

  // Gather lane results into sum/carry vectors and reduce the carries.
  always_comb begin
    s_comb         = '0;
    c_comb         = '0;
    carry_cnt_comb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s_comb[i]      = lane_res[i].sum;
      c_comb[i]      = lane_res[i].carry;
      carry_cnt_comb = carry_cnt_comb + CW'(lane_res[i].carry);
    end
    carry_any_comb = |c_comb;
  end

  // The valid pipeline is registered in both output modes.
  logic out_valid_q;
  logic out_valid_d;

  // Next valid state: a fresh result exists exactly when an operand pair arrived.
  always_comb begin
    out_valid_d = in_valid;
  end

  // Valid register; reset takes priority over an incoming operand pair.
  always_ff @(posedge clk) begin
    if (!rst_n) out_valid_q <= 1'b0;
    else        out_valid_q <= out_valid_d;
  end

  assign out_valid = out_valid_q;

  if (OUT_REG) begin : g_out_reg
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             carry_any_q, carry_any_d;
    logic [CW-1:0]    carry_cnt_q, carry_cnt_d;

    // Load new results only on in_valid; otherwise hold, so X on idle operands never leaks in.
    always_comb begin
      s_d         = s_q;
      c_d         = c_q;
      carry_any_d = carry_any_q;
      carry_cnt_d = carry_cnt_q;
      if (in_valid) begin
        s_d         = s_comb;
        c_d         = c_comb;
        carry_any_d = carry_any_comb;
        carry_cnt_d = carry_cnt_comb;
      end
    end

    // Result registers with synchronous clear.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s_q         <= '0;
        c_q         <= '0;
        carry_any_q <= 1'b0;
        carry_cnt_q <= '0;
      end else begin
        s_q         <= s_d;
        c_q         <= c_d;
        carry_any_q <= carry_any_d;
        carry_cnt_q <= carry_cnt_d;
      end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign carry_any = carry_any_q;
    assign carry_cnt = carry_cnt_q;
  end else begin : g_out_comb
    // Data outputs track the operands directly, regardless of in_valid or reset.
    assign s         = s_comb;
    assign c         = c_comb;
    assign carry_any = carry_any_comb;
    assign carry_cnt = carry_cnt_comb;
  end

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Directed bench for half_adder in three configurations sharing clock and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_half_adder;

  logic clk;
  logic rst_n;

  // WIDTH=1, registered outputs
  logic       iv1, a1, b1, ov1, s1, c1, any1;
  logic [0:0] cnt1;
  // WIDTH=4, registered outputs
  logic       iv4, ov4, any4;
  logic [3:0] a4, b4, s4, c4;
  logic [2:0] cnt4;
  // WIDTH=1, combinational outputs
  logic       iv0, a0, b0, ov0, s0, c0, any0;
  logic [0:0] cnt0;

  int n_vec;
  int n_err;

  half_adder #(.WIDTH(1), .OUT_REG(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1),
    .out_valid(ov1), .s(s1), .c(c1), .carry_any(any1), .carry_cnt(cnt1)
  );

  half_adder #(.WIDTH(4), .OUT_REG(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .a(a4), .b(b4),
    .out_valid(ov4), .s(s4), .c(c4), .carry_any(any4), .carry_cnt(cnt4)
  );

  half_adder #(.WIDTH(1), .OUT_REG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .a(a0), .b(b0),
    .out_valid(ov0), .s(s0), .c(c0), .carry_any(any0), .carry_cnt(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    iv0 = 1'b1; a0 = 1'b1; b0 = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({ov1, s1, c1, any1, cnt1} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_w1: got {ov,s,c,any,cnt}=%b want 00000", {ov1, s1, c1, any1, cnt1});
    end
    n_vec++;
    if ({ov4, s4, c4, any4, cnt4} !== 13'b0) begin
      n_err++;
      $display("FAIL reset_w4: got {ov,s,c,any,cnt}=%b want 0", {ov4, s4, c4, any4, cnt4});
    end
    // comb variant: valid cleared, data still follows a=1,b=1
    n_vec++;
    if ({ov0, s0, c0, any0, cnt0} !== 5'b00111) begin
      n_err++;
      $display("FAIL reset_comb: got {ov,s,c,any,cnt}=%b want 00111", {ov0, s0, c0, any0, cnt0});
    end
    rst_n = 1'b1;
    iv4 = 1'b0; iv0 = 1'b0;
    tick();
    n_vec++;
    if ({ov1, s1, c1, any1, cnt1} !== 5'b10111) begin
      n_err++;
      $display("FAIL reset_release: got {ov,s,c,any,cnt}=%b want 10111", {ov1, s1, c1, any1, cnt1});
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] ab  [4];
    logic [1:0] exp [4];
    ab  = '{2'b00, 2'b10, 2'b01, 2'b11};  // {a,b}
    exp = '{2'b00, 2'b10, 2'b10, 2'b01};  // {s,c}
    iv1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = ab[i];
      tick();
      n_vec++;
      if ({ov1, s1, c1} !== {1'b1, exp[i]}) begin
        n_err++;
        $display("FAIL truth_%0d: got {ov,s,c}=%b want %b", i, {ov1, s1, c1}, {1'b1, exp[i]});
      end
    end
  endtask

  task automatic test_mid_reset();
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    tick();
    a1 = 1'b1; b1 = 1'b1;
    tick();
    n_vec++;
    if ({ov1, s1, c1} !== 3'b101) begin
      n_err++;
      $display("FAIL midrst_pre: got {ov,s,c}=%b want 101", {ov1, s1, c1});
    end
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b0;
    tick();
    n_vec++;
    if ({ov1, s1, c1, any1, cnt1} !== 5'b00000) begin
      n_err++;
      $display("FAIL midrst_clear: got {ov,s,c,any,cnt}=%b want 00000", {ov1, s1, c1, any1, cnt1});
    end
    rst_n = 1'b1;
    iv1 = 1'b0;
    tick();
    n_vec++;
    if ({ov1, s1, c1, any1, cnt1} !== 5'b00000) begin
      n_err++;
      $display("FAIL midrst_stale: got {ov,s,c,any,cnt}=%b want 00000", {ov1, s1, c1, any1, cnt1});
    end
  endtask

  task automatic test_hold();
    logic [1:0] idle_ab [3];
    idle_ab = '{2'b01, 2'b11, 2'bxx};
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    tick();
    n_vec++;
    if ({ov1, s1, c1} !== 3'b110) begin
      n_err++;
      $display("FAIL hold_load: got {ov,s,c}=%b want 110", {ov1, s1, c1});
    end
    iv1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {a1, b1} = idle_ab[i];
      tick();
      n_vec++;
      if ({ov1, s1, c1, any1, cnt1} !== 5'b01000) begin
        n_err++;
        $display("FAIL hold_%0d: got {ov,s,c,any,cnt}=%b want 01000", i, {ov1, s1, c1, any1, cnt1});
      end
    end
  endtask

  task automatic test_width4();
    logic [7:0]  ab  [4];  // {a,b}
    logic [11:0] exp [4];  // {s,c,any,cnt}
    ab  = '{8'b1011_0110, 8'b1111_1111, 8'b1010_1100, 8'b0111_0111};
    exp = '{12'b1101_0010_1_001, 12'b0000_1111_1_100,
            12'b0110_1000_1_001, 12'b0000_0111_1_011};
    iv4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {a4, b4} = ab[i];
      tick();
      n_vec++;
      if ({ov4, s4, c4, any4, cnt4} !== {1'b1, exp[i]}) begin
        n_err++;
        $display("FAIL w4_%0d: got {ov,s,c,any,cnt}=%b want %b", i,
                 {ov4, s4, c4, any4, cnt4}, {1'b1, exp[i]});
      end
    end
    a4 = 4'b0000; b4 = 4'b0000;
    tick();
    n_vec++;
    if ({ov4, s4, c4, any4, cnt4} !== 13'b1_0000_0000_0_000) begin
      n_err++;
      $display("FAIL w4_zero: got {ov,s,c,any,cnt}=%b want 1000000000000", {ov4, s4, c4, any4, cnt4});
    end
    iv4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
    tick();
    n_vec++;
    if ({ov4, s4, c4, any4, cnt4} !== 13'b0_0000_0000_0_000) begin
      n_err++;
      $display("FAIL w4_hold: got {ov,s,c,any,cnt}=%b want 0000000000000", {ov4, s4, c4, any4, cnt4});
    end
  endtask

  task automatic test_comb();
    iv0 = 1'b0; a0 = 1'b0; b0 = 1'b0;
    tick();
    #2;
    a0 = 1'b1; b0 = 1'b0;
    #1;
    n_vec++;
    if ({ov0, s0, c0, any0, cnt0} !== 5'b01000) begin
      n_err++;
      $display("FAIL comb_10: got {ov,s,c,any,cnt}=%b want 01000", {ov0, s0, c0, any0, cnt0});
    end
    a0 = 1'b1; b0 = 1'b1;
    iv0 = 1'b1;
    #1;
    n_vec++;
    if ({ov0, s0, c0, any0, cnt0} !== 5'b00111) begin
      n_err++;
      $display("FAIL comb_11: got {ov,s,c,any,cnt}=%b want 00111", {ov0, s0, c0, any0, cnt0});
    end
    tick();
    n_vec++;
    if (ov0 !== 1'b1) begin
      n_err++;
      $display("FAIL comb_valid_lag: got ov=%b want 1", ov0);
    end
    iv0 = 1'b0;
    a0 = 1'b0; b0 = 1'b1;
    #1;
    n_vec++;
    if ({ov0, s0, c0} !== 3'b110) begin
      n_err++;
      $display("FAIL comb_01: got {ov,s,c}=%b want 110", {ov0, s0, c0});
    end
    tick();
    n_vec++;
    if (ov0 !== 1'b0) begin
      n_err++;
      $display("FAIL comb_valid_drop: got ov=%b want 0", ov0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    iv4 = 1'b0; a4 = '0;   b4 = '0;
    iv0 = 1'b0; a0 = 1'b0; b0 = 1'b0;
    test_reset();
    test_truth_table();
    test_mid_reset();
    test_hold();
    test_width4();
    test_comb();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_half_adder
